// File: rtl/dram_arbiter_pkg.sv
// Shared types and sizing helpers for the dram_arbiter slice.
package dram_arbiter_pkg;

  // Arbiter sequencing: accept a request, wait one cycle for read data, then hold the response.
  typedef enum logic [1:0] {
    READY   = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } dram_arb_state_e;

  // Number of bytes in one data word.
  function automatic int byte_count(input int data_width);
    return data_width / 8;
  endfunction

  // Number of low address bits that select a byte within one data word.
  function automatic int offset_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/dram_arbiter_rr_arbiter.sv
// Reusable round-robin arbiter: one-hot grant searched from the slot after the last winner.
module rr_arbiter #(
  parameter int num_req_p = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_req_p-1:0]         req_i,
  input  logic                         en_i,
  output logic [num_req_p-1:0]         grant_o,
  output logic [$clog2(num_req_p)-1:0] grant_id_o,
  output logic                         grant_v_o
);

  localparam int id_width_lp = $clog2(num_req_p);

  logic [id_width_lp-1:0] last_r;
  logic [id_width_lp-1:0] cand;

  // Walk the requesters starting just after the last winner and take the first valid one.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    grant_o    = '0;
    grant_id_o = '0;
    grant_v_o  = 1'b0;
    cand       = last_r;
    for (int k = 0; k < num_req_p; k++) begin
      if (cand == id_width_lp'(num_req_p - 1)) cand = '0;
      else                                     cand = cand + 1'b1;
      if (en_i && !grant_v_o && req_i[cand]) begin
        grant_v_o     = 1'b1;
        grant_id_o    = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

  // Remember the winner so it has lowest priority next time; reset favours requester 0.
  always_ff @(posedge clk_i) begin
    // NOTE: registered state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset_i)        last_r <= id_width_lp'(num_req_p - 1);
    else if (grant_v_o) last_r <= grant_id_o;
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single-port dram between several requesters: round-robin grant,
// address rebasing/range check, one outstanding transaction, held response.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int                      num_req_p          = 2,
  parameter int                      data_width_p       = 64,
  parameter int                      addr_width_p       = 32,
  parameter logic [addr_width_p-1:0] dram_base_p        = 32'h8000_0000,
  parameter longint                  mem_cap_in_bytes_p = 64'd268435456
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p-1:0]                  req_w_i,
  input  logic [num_req_p*addr_width_p-1:0]     req_addr_i,
  input  logic [num_req_p*data_width_p-1:0]     req_data_i,
  input  logic [num_req_p*(data_width_p/8)-1:0] req_mask_i,
  output logic [num_req_p-1:0]                  req_yumi_o,
  output logic [num_req_p-1:0]                  resp_v_o,
  output logic [data_width_p-1:0]               resp_data_o,
  output logic                                  resp_err_o,
  input  logic [num_req_p-1:0]                  resp_yumi_i,
  output logic                                  dram_v_o,
  output logic                                  dram_w_o,
  output logic [addr_width_p-1:0]               dram_addr_o,
  output logic [data_width_p-1:0]               dram_data_o,
  output logic [data_width_p/8-1:0]             dram_mask_o,
  input  logic [data_width_p-1:0]               dram_data_i
);

  localparam int bytes_lp    = byte_count(data_width_p);
  localparam int off_lp      = offset_width(data_width_p);
  localparam int id_width_lp = $clog2(num_req_p);

  // Range arithmetic is one bit wider than the address so nothing wraps.
  localparam logic [addr_width_p:0]   base_ext_lp   = {1'b0, dram_base_p};
  localparam logic [addr_width_p:0]   cap_ext_lp    = (addr_width_p + 1)'(mem_cap_in_bytes_p);
  localparam logic [addr_width_p:0]   bytes_ext_lp  = (addr_width_p + 1)'(bytes_lp);
  localparam logic [addr_width_p-1:0] align_mask_lp = ~(addr_width_p'((1 << off_lp) - 1));

  dram_arb_state_e state_r, state_n;

  logic [id_width_lp-1:0]  owner_r;
  logic [data_width_p-1:0] resp_data_r;
  logic                    resp_err_r;

  logic [num_req_p-1:0]    grant;
  logic [id_width_lp-1:0]  grant_id;
  logic                    grant_v;
  logic                    grant_en;

  logic                      sel_w;
  logic [addr_width_p-1:0]   sel_addr;
  logic [data_width_p-1:0]   sel_data;
  logic [data_width_p/8-1:0] sel_mask;
  logic [addr_width_p:0]     addr_ext;
  logic [addr_width_p:0]     offset_ext;
  logic                      in_range;
  logic                      issue;

  // Grants are only offered when idle; reset also suppresses them so outputs stay quiet.
  assign grant_en = (state_r == READY) && !reset_i;

  rr_arbiter #(
    .num_req_p (num_req_p)
  ) u_rr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .req_i      (req_v_i),
    .en_i       (grant_en),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .grant_v_o  (grant_v)
  );

  // One-hot mux of the granted requester's fields.
  always_comb begin
    sel_w    = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_mask = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant[i]) begin
        sel_w    = req_w_i[i];
        sel_addr = req_addr_i[i*addr_width_p +: addr_width_p];
        sel_data = req_data_i[i*data_width_p +: data_width_p];
        sel_mask = req_mask_i[i*bytes_lp +: bytes_lp];
      end
    end
  end

  assign addr_ext   = {1'b0, sel_addr};
  assign offset_ext = addr_ext - base_ext_lp;
  assign in_range   = (addr_ext >= base_ext_lp) && ((offset_ext + bytes_ext_lp) <= cap_ext_lp);
  assign issue      = grant_v && in_range;

  assign req_yumi_o  = grant;
  assign dram_v_o    = issue;
  assign dram_w_o    = issue && sel_w;
  assign dram_addr_o = issue ? (offset_ext[addr_width_p-1:0] & align_mask_lp) : '0;
  assign dram_data_o = issue ? sel_data : '0;
  assign dram_mask_o = issue ? sel_mask : '0;

  assign resp_data_o = (state_r == RESP) ? resp_data_r : '0;
  assign resp_err_o  = (state_r == RESP) && resp_err_r;

  // Response valid is steered to the owner only while the response is held.
  always_comb begin
    resp_v_o = '0;
    if (state_r == RESP) resp_v_o[owner_r] = 1'b1;
  end

  // Next-state: reads take a data-wait cycle, writes and errors go straight to the response.
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      READY:   if (grant_v) state_n = (in_range && !sel_w) ? RD_WAIT : RESP;
      RD_WAIT: state_n = RESP;
      RESP:    if (resp_yumi_i[owner_r]) state_n = READY;
      default: state_n = READY;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= READY;
    else         state_r <= state_n;
  end

  // Response registers: owner and error set at grant, read data captured in the wait cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_r     <= '0;
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
    end else begin
      if (state_r == READY && grant_v) begin
        owner_r     <= grant_id;
        resp_data_r <= '0;
        resp_err_r  <= !in_range;
      end else if (state_r == RD_WAIT) begin
        resp_data_r <= dram_data_i;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small behavioural dram model.
module tb_dram_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int MB = DW / 8;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [N-1:0]      req_v_i, req_w_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_data_i;
  logic [N*MB-1:0]   req_mask_i;
  logic [N-1:0]      req_yumi_o, resp_v_o, resp_yumi_i;
  logic [DW-1:0]     resp_data_o;
  logic              resp_err_o;
  logic              dram_v_o, dram_w_o;
  logic [AW-1:0]     dram_addr_o;
  logic [DW-1:0]     dram_data_o;
  logic [MB-1:0]     dram_mask_o;
  logic [DW-1:0]     dram_data_i;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  localparam logic [63:0] D_FULL = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D_PART = 64'h1111_1111_2222_2222;
  localparam logic [63:0] D_MRG  = 64'hDEAD_BEEF_2222_2222;
  localparam logic [63:0] D_R1   = 64'h0BAD_F00D_CAFE_0001;

  dram_arbiter dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_v_i     (req_v_i),
    .req_w_i     (req_w_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_mask_i  (req_mask_i),
    .req_yumi_o  (req_yumi_o),
    .resp_v_o    (resp_v_o),
    .resp_data_o (resp_data_o),
    .resp_err_o  (resp_err_o),
    .resp_yumi_i (resp_yumi_i),
    .dram_v_o    (dram_v_o),
    .dram_w_o    (dram_w_o),
    .dram_addr_o (dram_addr_o),
    .dram_data_o (dram_data_o),
    .dram_mask_o (dram_mask_o),
    .dram_data_i (dram_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural dram: 16 words, byte-masked writes, read data one cycle after issue.
  logic [63:0] mem [0:15];
  logic [3:0]  mem_idx;
  assign mem_idx = dram_addr_o[6:3];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    dram_data_i = '0;
  end

  always @(posedge clk_i) begin
    if (dram_v_o && dram_w_o) begin
      for (int b = 0; b < MB; b++)
        if (dram_mask_o[b]) mem[mem_idx][b*8 +: 8] <= dram_data_o[b*8 +: 8];
    end else if (dram_v_o) begin
      dram_data_i <= mem[mem_idx];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_reqs();
    req_v_i    = '0;
    req_w_i    = '0;
    req_addr_i = '0;
    req_data_i = '0;
    req_mask_i = '0;
  endtask

  task automatic set_req(input int r, input logic w, input logic [31:0] addr,
                         input logic [63:0] data, input logic [7:0] mask);
    req_v_i[r]               = 1'b1;
    req_w_i[r]               = w;
    req_addr_i[r*AW +: AW]   = addr;
    req_data_i[r*DW +: DW]   = data;
    req_mask_i[r*MB +: MB]   = mask;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_yumi"}, 64'(req_yumi_o), 64'd0);
    check({tag, "_resp_v"},   64'(resp_v_o),   64'd0);
    check({tag, "_resp_data"}, resp_data_o,    64'd0);
    check({tag, "_resp_err"}, 64'(resp_err_o), 64'd0);
    check({tag, "_dram_v"},   64'(dram_v_o),   64'd0);
    check({tag, "_dram_w"},   64'(dram_w_o),   64'd0);
    check({tag, "_dram_addr"}, 64'(dram_addr_o), 64'd0);
    check({tag, "_dram_data"}, dram_data_o,    64'd0);
    check({tag, "_dram_mask"}, 64'(dram_mask_o), 64'd0);
  endtask

  // Write: grant and dram issue in the same cycle, response one cycle later.
  task automatic do_write(input int r, input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] mask, input logic [31:0] exp_daddr);
    clear_reqs();
    set_req(r, 1'b1, addr, data, mask);
    #1;
    check("wr_yumi",      64'(req_yumi_o),  64'(1 << r));
    check("wr_dram_v",    64'(dram_v_o),    64'd1);
    check("wr_dram_w",    64'(dram_w_o),    64'd1);
    check("wr_dram_addr", 64'(dram_addr_o), 64'(exp_daddr));
    check("wr_dram_data", dram_data_o,      data);
    check("wr_dram_mask", 64'(dram_mask_o), 64'(mask));
    cyc();
    clear_reqs();
    #1;
    check("wr_resp_v",    64'(resp_v_o),    64'(1 << r));
    check("wr_resp_err",  64'(resp_err_o),  64'd0);
    check("wr_resp_data", resp_data_o,      64'd0);
    check("wr_dram_idle", 64'(dram_v_o),    64'd0);
    resp_yumi_i = N'(1 << r);
    cyc();
    resp_yumi_i = '0;
    #1;
    check("wr_resp_done", 64'(resp_v_o), 64'd0);
  endtask

  // Read (or out-of-range access): response after 2 cycles, or 1 cycle for errors.
  task automatic do_read(input int r, input logic [31:0] addr, input logic [31:0] exp_daddr,
                         input logic [63:0] exp_data, input logic exp_err);
    clear_reqs();
    set_req(r, 1'b0, addr, 64'd0, 8'd0);
    #1;
    check("rd_yumi",   64'(req_yumi_o), 64'(1 << r));
    check("rd_dram_v", 64'(dram_v_o),   64'(!exp_err));
    check("rd_dram_w", 64'(dram_w_o),   64'd0);
    if (!exp_err) check("rd_dram_addr", 64'(dram_addr_o), 64'(exp_daddr));
    cyc();
    clear_reqs();
    #1;
    if (!exp_err) begin
      check("rd_wait_resp_v", 64'(resp_v_o),   64'd0);
      check("rd_wait_yumi",   64'(req_yumi_o), 64'd0);
      cyc();
      #1;
    end
    check("rd_resp_v",    64'(resp_v_o),   64'(1 << r));
    check("rd_resp_data", resp_data_o,     exp_data);
    check("rd_resp_err",  64'(resp_err_o), 64'(exp_err));
    check("rd_dram_idle", 64'(dram_v_o),   64'd0);
    resp_yumi_i = N'(1 << r);
    cyc();
    resp_yumi_i = '0;
    #1;
  endtask

  int gcount, rcount, last_gc;

  initial begin
    reset_i     = 1'b1;
    resp_yumi_i = '0;
    clear_reqs();
    repeat (3) cyc();
    reset_i = 1'b0;
    #1;
    check_idle("reset");

    // Full write, read back, partial-mask merge.
    do_write(0, 32'h8000_0010, D_FULL, 8'hFF, 32'h10);
    do_read (0, 32'h8000_0010, 32'h10, D_FULL, 1'b0);
    do_write(0, 32'h8000_0010, D_PART, 8'h0F, 32'h10);
    do_read (0, 32'h8000_0010, 32'h10, D_MRG, 1'b0);

    // Requester 1 content, then range boundaries (leaves pointer on requester 1).
    do_write(1, 32'h8000_0020, D_R1, 8'hFF, 32'h20);
    do_read (1, 32'h7FFF_FFF8, 32'h0,         64'd0, 1'b1);
    do_read (1, 32'h8FFF_FFFC, 32'h0,         64'd0, 1'b1);
    do_read (1, 32'h8FFF_FFF8, 32'h0FFF_FFF8, 64'd0, 1'b0);

    // Both requesters reading continuously with immediate response acceptance.
    clear_reqs();
    set_req(0, 1'b0, 32'h8000_0010, 64'd0, 8'd0);
    set_req(1, 1'b0, 32'h8000_0020, 64'd0, 8'd0);
    resp_yumi_i = 2'b11;
    #1;
    gcount  = 0;
    rcount  = 0;
    last_gc = -3;
    for (int c = 0; c < 12; c++) begin
      if (req_yumi_o != '0) begin
        check("rr_grant",   64'(req_yumi_o), 64'(1 << (gcount % 2)));
        check("rr_spacing", 64'(c - last_gc), 64'd3);
        last_gc = c;
        gcount++;
      end
      if (resp_v_o != '0) begin
        check("rr_resp_owner", 64'(resp_v_o), 64'(1 << ((gcount - 1) % 2)));
        check("rr_resp_data",  resp_data_o, ((gcount - 1) % 2 == 1) ? D_R1 : D_MRG);
        rcount++;
      end
      cyc();
      #1;
    end
    check("rr_grant_count", 64'(gcount), 64'd4);
    check("rr_resp_count",  64'(rcount), 64'd4);
    clear_reqs();
    resp_yumi_i = '0;
    #1;

    // Response backpressure with requester 1 waiting; wrong-owner yumi is ignored.
    set_req(0, 1'b0, 32'h8000_0010, 64'd0, 8'd0);
    #1;
    check("bp_grant0", 64'(req_yumi_o), 64'b01);
    cyc();
    clear_reqs();
    set_req(1, 1'b0, 32'h8000_0020, 64'd0, 8'd0);
    #1;
    check("bp_wait_yumi", 64'(req_yumi_o), 64'd0);
    cyc();
    #1;
    for (int i = 0; i < 5; i++) begin
      resp_yumi_i = 2'b10;
      #1;
      check("bp_resp_v",    64'(resp_v_o),   64'b01);
      check("bp_resp_data", resp_data_o,     D_MRG);
      check("bp_no_grant",  64'(req_yumi_o), 64'd0);
      check("bp_dram_idle", 64'(dram_v_o),   64'd0);
      cyc();
    end
    resp_yumi_i = 2'b01;
    #1;
    check("bp_yumi_cycle_resp_v", 64'(resp_v_o),   64'b01);
    check("bp_yumi_cycle_grant",  64'(req_yumi_o), 64'd0);
    cyc();
    resp_yumi_i = '0;
    #1;
    check("bp_grant1",      64'(req_yumi_o),  64'b10);
    check("bp_resp_clear",  64'(resp_v_o),    64'd0);
    check("bp_grant1_addr", 64'(dram_addr_o), 64'h20);
    cyc();
    clear_reqs();
    cyc();
    #1;
    check("bp_r1_resp_v",    64'(resp_v_o), 64'b10);
    check("bp_r1_resp_data", resp_data_o,   D_R1);
    resp_yumi_i = 2'b10;
    cyc();
    resp_yumi_i = '0;
    #1;

    // Reset during RD_WAIT after a requester-0 grant; pointer must return to requester 0.
    set_req(0, 1'b0, 32'h8000_0010, 64'd0, 8'd0);
    #1;
    check("rst_pre_grant", 64'(req_yumi_o), 64'b01);
    cyc();
    clear_reqs();
    reset_i = 1'b1;
    #1;
    cyc();
    reset_i = 1'b0;
    #1;
    check_idle("rst_after");
    cyc();
    #1;
    check("rst_no_stale_resp", 64'(resp_v_o), 64'd0);
    set_req(0, 1'b0, 32'h8000_0010, 64'd0, 8'd0);
    set_req(1, 1'b0, 32'h8000_0020, 64'd0, 8'd0);
    #1;
    check("rst_first_grant", 64'(req_yumi_o), 64'b01);
    cyc();
    clear_reqs();
    cyc();
    #1;
    check("rst_resp_v",    64'(resp_v_o), 64'b01);
    check("rst_resp_data", resp_data_o,   D_MRG);
    resp_yumi_i = 2'b01;
    cyc();
    resp_yumi_i = '0;
    #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single-port, byte-addressed `dram` behavioural memory between `num_req_p` requesters (e.g. I-fetch and D-side of the testbench).
- Accepts one transaction at a time, rebases and aligns the address, and drives the `dram` port.
- For reads, captures the `dram` read data (valid one cycle after issue) into a response register. The response is held until the owning requester accepts it.
- Out-of-range accesses complete with an error response and never touch `dram`.

Parameters:
- num_req_p, 2, number of requesters (≥2)
- data_width_p, 64, data width; must match `dram`
- addr_width_p, 32, address width
- dram_base_p, 32'h8000_0000, physical address mapped to `dram` byte 0
- mem_cap_in_bytes_p, 2**28, `dram` capacity in bytes

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous reset, active-high
- req_v_i  in  num_req_p  request valid, one bit per requester
- req_w_i  in  num_req_p  1 = write, 0 = read
- req_addr_i  in  num_req_p*addr_width_p  byte address; requester i at slice [i*addr_width_p +: addr_width_p]
- req_data_i  in  num_req_p*data_width_p  write data
- req_mask_i  in  num_req_p*(data_width_p/8)  byte write mask
- req_yumi_o  out  num_req_p  request accepted this cycle (one-hot or zero)
- resp_v_o  out  num_req_p  response valid for requester i (one-hot or zero)
- resp_data_o  out  data_width_p  read data; zero for writes and errors
- resp_err_o  out  1  address out of range
- resp_yumi_i  in  num_req_p  requester consumes response
- dram_v_o  out  1  `dram` valid
- dram_w_o  out  1  `dram` write enable
- dram_addr_o  out  addr_width_p  `dram` byte address (rebased, aligned)
- dram_data_o  out  data_width_p  `dram` write data
- dram_mask_o  out  data_width_p/8  `dram` write mask
- dram_data_i  in  data_width_p  `dram` read data

Behaviour:
- Reset values:
  - All outputs 0; state = READY.
  - Round-robin pointer `last_r` = num_req_p-1, so requester 0 has first priority.
  - Response registers cleared.
- FSM states: READY, RD_WAIT, RESP.
- READY:
  - If any `req_v_i` is set, grant the first set index searching from `last_r+1` with wrap. The grant is combinational in the same cycle: `req_yumi_o[g]=1` and `last_r<=g`.
  - Range check: offset = addr − dram_base_p. The access is in range iff addr ≥ dram_base_p and offset + data_width_p/8 ≤ mem_cap_in_bytes_p. Compute at addr_width_p+1 bits so there is no wrap.
  - In range:
    - `dram_v_o=1`, `dram_w_o=req_w`, `dram_addr_o` = offset with the low log2(data_width_p/8) bits forced to 0, `dram_data_o/dram_mask_o` passed through.
    - Write → RESP with `resp_data` = 0, `err` = 0.
    - Read → RD_WAIT.
  - Out of range: `dram_v_o=0`; → RESP with `err` = 1, data = 0.
  - Record owner = g.
- RD_WAIT (exactly one cycle):
  - Capture `dram_data_i` into the response data register; → RESP.
  - `req_yumi_o` = 0.
- RESP:
  - `resp_v_o[owner]=1` with the registered data and error held stable.
  - On `resp_yumi_i[owner]` → READY; no grant in that same cycle.
  - `resp_yumi_i` on any other bit is ignored.
- Latency:
  - Read grant → `resp_v_o` is 2 cycles.
  - Write or error grant → `resp_v_o` is 1 cycle.
  - Minimum issue interval is 3 cycles for reads and 2 for writes.
- `dram_v_o` is high only in the grant cycle; all `dram_*` outputs are 0 when not issuing.
- `req_yumi_o` is never asserted outside READY and never without the matching `req_v_i`.
- Requesters may drop or change requests freely before yumi; the arbiter samples only in the grant cycle.
- Reset mid-operation (RD_WAIT or RESP): the in-flight response is discarded, all outputs return to reset values the next cycle, and the pointer is reset.
- Single requester repeatedly valid: it is granted every opportunity. With all requesters valid, grants rotate 0, 1, …, n-1, 0.

Decomposition:
- Package `dram_arbiter_pkg`:
  - State enum `dram_arb_state_e` {READY, RD_WAIT, RESP}.
  - Localparam helpers: byte count = data_width_p/8, offset width = $clog2(byte count).
- Sub-module `rr_arbiter` (num_req_p requests, grant enable, one-hot grant, `last_r` pointer update), kept reusable.

Test Plan:
- Write then read, requester 0, addr 0x8000_0010, data 0xDEAD_BEEF_0123_4567, mask 0xFF:
  - Write → `dram_addr_o`=0x10, `resp_v_o`=01 one cycle after yumi.
  - Read → `resp_data_o`=0xDEAD_BEEF_0123_4567 two cycles after yumi.
- Partial write mask 0x0F with data 0x1111_1111_2222_2222 over the previous value, then read → 0xDEAD_BEEF_2222_2222.
- Both requesters continuously valid (reads) with immediate `resp_yumi_i`:
  - Grants are 0, 1, 0, 1.
  - Each grant lands 3 cycles apart.
  - `resp_v_o` is one-hot to the correct owner each time.
- Out of range:
  - addr 0x7FFF_FFF8 → `resp_err_o`=1, `dram_v_o` never high.
  - addr 0x8000_0000+2**28−4 → `err`=1.
  - addr 0x8000_0000+2**28−8 → `err`=0.
- Response backpressure: hold `resp_yumi_i`=0 for 5 cycles with requester 1 valid:
  - `resp_v_o` and `resp_data_o` stay stable.
  - `req_yumi_o` stays 0.
  - Requester 1 is granted the cycle after the yumi cycle.
- Assert `reset_i` during RD_WAIT:
  - Next cycle, all outputs are 0 and state is READY.
  - First grant afterwards goes to requester 0 when both are valid.
